div_unit: RTL and testbench



---
 rtl/div_unit.sv | 151 +++++++++++++++
 tb/tb_div_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Sequential signed restoring divider: quotient on lo, remainder on hi, one quotient bit per cycle.
// Optional macro DIV_ZERO_EXC_EN: a zero divisor raises a one-cycle dzero pulse instead of running.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dzero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
`ifdef DIV_ZERO_EXC_EN
    logic             dzero_q, dzero_d;
`endif

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case leaves it unassigned (no latch).
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
`ifdef DIV_ZERO_EXC_EN
        dzero_d = 1'b0;
`endif

        dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

        // The remainder stays below the divisor magnitude (at most 2^(WIDTH-1)), so WIDTH+1 bits hold the sign.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};

        unique case (state_q)
            IDLE: begin
                if (div_start) begin
`ifdef DIV_ZERO_EXC_EN
                    if (divisor == '0) dzero_d = 1'b1;
                    else
`endif
                    begin
                        sq_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sr_d    = dividend[WIDTH-1];
                        quo_d   = dividend_mag;
                        dvs_d   = divisor_mag;
                        rem_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                lo_d    = sq_q ? -quo_q : quo_q;
                hi_d    = sr_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
            dzero_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
`ifdef DIV_ZERO_EXC_EN
            dzero_q <= dzero_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef DIV_ZERO_EXC_EN
    assign dzero = dzero_q;
`else
    assign dzero = 1'b0;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected hi/lo come from a 64-bit signed reference and are queued at start.
module tb_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dzero;

    int   checks = 0;
    int   errors = 0;
    exp_t scb[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .div_start(div_start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .dzero    (dzero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            e.hi = a;
            e.lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; returns #1 after E0 with div_start already dropped.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit push);
        div_start = 1'b1;
        dividend  = a;
        divisor   = b;
        if (push) scb.push_back(model(a, b));
        step();
        div_start = 1'b0;
    endtask

    // Entered #1 after E0; returns #1 after the edge that raised done (or on timeout).
    task automatic wait_done(input string tag, input int inject_at);
        int   cyc = 0;
        bit   busy_ok = 1'b1;
        bit   dz_seen = 1'b0;
        exp_t e;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (dzero !== 1'b0) dz_seen = 1'b1;
            if (cyc == inject_at) begin
                div_start = 1'b1;
                dividend  = 32'd9;
                divisor   = 32'd3;
            end else if (cyc == inject_at + 1) begin
                div_start = 1'b0;
            end
            step();
            cyc++;
        end
        div_start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_no_dzero"}, 64'(dz_seen), 64'd0);
        check({tag, "_scb_nonempty"}, 64'(scb.size() != 0), 64'd1);
        if (scb.size() != 0) begin
            e = scb.pop_front();
            check({tag, "_lo"}, 64'(lo), 64'(e.lo));
            check({tag, "_hi"}, 64'(hi), 64'(e.hi));
            last_hi = e.hi;
            last_lo = e.lo;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b);
        do_start(a, b, 1'b1);
        wait_done(tag, -10);
        step();
        check({tag, "_done_low"}, 64'(done), 64'd0);
    endtask

    initial begin
        bit done_seen;
        reset     = 1'b1;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dzero", 64'(dzero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        step();

        run_div("p7_p2", 32'd7, 32'd2);
        run_div("n7_p2", 32'hFFFF_FFF9, 32'd2);
        run_div("p7_n2", 32'd7, 32'hFFFF_FFFE);
        run_div("n7_n2", 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        run_div("min_n1", 32'h8000_0000, 32'hFFFF_FFFF);
        check("min_n1_lo_const", 64'(lo), 64'h8000_0000);
        run_div("min_p1", 32'h8000_0000, 32'd1);

`ifdef DIV_ZERO_EXC_EN
        do_start(32'd100, 32'd0, 1'b0);
        check("dz_pulse", 64'(dzero), 64'd1);
        check("dz_busy", 64'(busy), 64'd0);
        step();
        check("dz_pulse_end", 64'(dzero), 64'd0);
        check("dz_busy2", 64'(busy), 64'd0);
        check("dz_done", 64'(done), 64'd0);
        check("dz_hi_kept", 64'(hi), 64'(last_hi));
        check("dz_lo_kept", 64'(lo), 64'(last_lo));
`else
        run_div("p100_z", 32'd100, 32'd0);
        check("p100_z_lo_const", 64'(lo), 64'hFFFF_FFFF);
        run_div("n5_z", 32'hFFFF_FFFB, 32'd0);
`endif

        // Start arriving mid-run is dropped; start in the done cycle is accepted.
        do_start(32'd50, 32'd5, 1'b1);
        wait_done("p50_p5", 10);
        do_start(32'd9, 32'd3, 1'b1);
        check("b2b_done_low", 64'(done), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done("p9_p3", -10);
        step();
        check("p9_p3_done_low", 64'(done), 64'd0);

        // Asynchronous reset mid-operation aborts it.
        do_start(32'd1000, 32'd7, 1'b1);
        repeat (15) step();
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        scb.delete();
        step();
        reset = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) done_seen = 1'b1;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        run_div("p1000_p7", 32'd1000, 32'd7);
        check("p1000_p7_lo_const", 64'(lo), 64'd142);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
